// File: rtl/avalon_m0_responder.sv
// avalon_m0_responder: pipelined Avalon-MM memory target for the 256-bit m0
// master, with fixed read latency, injected stalls and read throttling.
module avalon_m0_responder #(
    parameter int ADDR_LSB     = 5,
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 4,
    parameter int MAX_PENDING  = 8,
    parameter int WAIT_EVERY   = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  avs_address,
    input  logic         avs_read,
    input  logic         avs_write,
    input  logic [255:0] avs_writedata,
    output logic         avs_waitrequest,
    output logic         avs_readdatavalid,
    output logic [255:0] avs_readdata,
    output logic [31:0]  rd_count,
    output logic [31:0]  wr_count,
    output logic         proto_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam logic [PW-1:0] PMAX = PW'(MAX_PENDING);

    logic [DEPTH_LOG2-1:0]   w_idx;
    logic                    w_stall_hit;
    logic                    w_acc;
    logic                    w_rd_acc;
    logic                    w_wr_acc;
    logic                    w_ret;

    logic [255:0]            r_mem [DEPTH];
    logic [READ_LATENCY-1:0] r_vld;
    logic [255:0]            r_dat [READ_LATENCY];
    logic [PW-1:0]           r_pending;
    logic [31:0]             r_rd_cnt;
    logic [31:0]             r_wr_cnt;
    logic                    r_proto;

    assign w_idx = avs_address[ADDR_LSB+DEPTH_LOG2-1:ADDR_LSB];

    generate
        if (WAIT_EVERY >= 2) begin : g_stall
            localparam int SW = $clog2(WAIT_EVERY);
            localparam logic [SW-1:0] SLAST = SW'(WAIT_EVERY - 1);
            logic [SW-1:0] r_sc;
            // Free-running phase counter; last phase forces a stall
            always_ff @(posedge clk) begin
                if (reset || r_sc == SLAST) begin
                    r_sc <= '0;
                end else begin
                    r_sc <= r_sc + SW'(1);
                end
            end
            assign w_stall_hit = (r_sc == SLAST);
        end else begin : g_nostall
            assign w_stall_hit = 1'b0;
        end
    endgenerate

    assign avs_waitrequest = reset | w_stall_hit | (r_pending == PMAX);

    assign w_acc    = (avs_read | avs_write) & ~avs_waitrequest;
    assign w_rd_acc = w_acc & avs_read;
    assign w_wr_acc = w_acc & avs_write & ~avs_read;

    // A read leaves the pending set on the edge its valid reaches the port
    generate
        if (READ_LATENCY == 1) begin : g_ret1
            assign w_ret = w_rd_acc;
        end else begin : g_retn
            assign w_ret = r_vld[READ_LATENCY-2];
        end
    endgenerate

    // Local RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_idx] <= avs_writedata;
        end
    end

    // Read valid shift chain
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_rd_acc;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    // Read data chain; each stage only moves with a valid so the port holds
    always_ff @(posedge clk) begin
        if (w_rd_acc) begin
            r_dat[0] <= r_mem[w_idx];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            if (r_vld[i-1]) begin
                r_dat[i] <= r_dat[i-1];
            end
        end
        if (reset) begin
            r_dat[READ_LATENCY-1] <= '0;
        end
    end

    // Outstanding read counter driving the throttle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else if (w_rd_acc && !w_ret) begin
            r_pending <= r_pending + PW'(1);
        end else if (!w_rd_acc && w_ret) begin
            r_pending <= r_pending - PW'(1);
        end
    end

    // Command counters and sticky protocol error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_proto  <= 1'b0;
        end else begin
            if (w_rd_acc) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (w_wr_acc) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
            if (w_rd_acc && avs_write) begin
                r_proto <= 1'b1;
            end
        end
    end

    assign avs_readdatavalid = r_vld[READ_LATENCY-1] & ~reset;
    assign avs_readdata      = reset ? '0 : r_dat[READ_LATENCY-1];
    assign rd_count          = r_rd_cnt;
    assign wr_count          = r_wr_cnt;
    assign proto_err         = r_proto;

endmodule
